sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Shares the single external SRAM port (18-bit address, 16-bit data, active-low write enable) between up to four decoder engines: colourspace conversion/upsampling, IDCT and dequantisation, and the UART/VGA movers. Ownership is granted per burst in round-robin order. Before ownership passes to the next engine, all reads in flight on the SRAM pipeline are drained, so read data is always tagged to the engine that issued it. The block sits between the top-level FSM's engine instances and the SRAM controller pins.

Parameters:
NUM_REQ, 3, number of requesters (1..4)
READ_LATENCY, 2, cycles from address on SRAM pins to valid SRAM_read_data (1..4)
BURST_LIMIT, 0, max accesses per grant; 0 = unlimited (1..255 otherwise)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester access request; bit i high = one access per cycle while granted
req_addr  in  18*NUM_REQ  packed addresses, requester i at [18*i+17:18*i]
req_we_n  in  NUM_REQ  per-requester write enable, active low; 1 = read
req_wdata  in  16*NUM_REQ  packed write data, requester i at [16*i+15:16*i]
grant  out  NUM_REQ  one-hot ownership, registered
rd_valid  out  NUM_REQ  one-hot; SRAM_read_data belongs to requester i this cycle
SRAM_read_data  in  16  read data from SRAM controller
SRAM_address  out  18  registered address to SRAM
SRAM_write_data  out  16  registered write data
SRAM_we_n  out  1  registered write enable, active low
busy  out  1  high in OWN or DRAIN

Behaviour:
- Reset (asynchronous, any time including mid-burst): state=IDLE, grant=0, rd_valid=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, busy=0, rr_ptr=0, tag pipeline cleared, burst count=0. In-flight reads are discarded; no rd_valid pulses after reset.
- States: IDLE, OWN, DRAIN.
- IDLE: if req!=0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ). grant<=onehot(winner), state<=OWN. No SRAM access is issued in this cycle.
- OWN, owner o: each cycle with req[o]=1 is an accepted access. On that edge: SRAM_address<=addr[o], SRAM_we_n<=we_n[o], SRAM_write_data<=wdata[o], burst count +1. An access is accepted on the same edge grant is first observed high by the requester, i.e. the first cycle grant[o]=1.
- OWN with req[o]=0: SRAM_we_n<=1; SRAM_address and SRAM_write_data hold their values; grant<=0; state<=DRAIN.
- BURST_LIMIT>0: the access that makes the count equal BURST_LIMIT is the last one. On that same edge grant<=0 and state<=DRAIN. A requester still holding req waits for a later grant.
- Pins are driven only in OWN. SRAM_we_n=1 in IDLE and DRAIN.
- Read tagging: each accepted read (we_n=1) pushes onehot(o) into a READ_LATENCY-deep tag shift register, and writes push 0. rd_valid = tag output, asserted exactly READ_LATENCY cycles after the address appeared on SRAM_address.
- DRAIN: stay until the tag pipeline is all zero (at most READ_LATENCY cycles), then rr_ptr<=(o+1) mod NUM_REQ and state<=IDLE. New requests, including from o, are ignored during DRAIN.
- Minimum gap between bursts of different owners: DRAIN length + 1 IDLE cycle.
- Simultaneous requests: round-robin only. The previous owner has the lowest priority on the next arbitration.
- busy = (state!=IDLE).
- Requester changes of addr/we_n/wdata while not granted are ignored.

Test Plan:
- Single read burst: req[0]=1 for 4 accesses at addr 0..3, SRAM returns 16'hA000+addr -> grant[0] rises 1 cycle after req; SRAM_address 0,1,2,3 on consecutive cycles; rd_valid[0] high 4 cycles, starting 2 cycles after address 0 on pins; data A000..A003.
- Contention: req=3'b111 constant, BURST_LIMIT=2 -> grants 0,1,2,0 in order; each burst is exactly 2 accesses; no grant overlap; ≥1 idle cycle between grants.
- Write then handover: req[1] writes 16'h1234 to 18'd146944, then req[2] reads 18'd38400 -> SRAM_we_n low exactly one cycle with correct address/data; read tag rd_valid[2] only, never rd_valid[1].
- Drain correctness: owner 0 issues reads, drops req while req[1] is high -> grant[1] is withheld until rd_valid[0] has fired for the last read; rd_valid never one-hot to 1 for owner 0's data.
- Reset mid-burst: assert Reset 1 cycle after 2 reads are issued -> immediately grant=0, SRAM_we_n=1, rd_valid stays 0 for the next READ_LATENCY+2 cycles; after release, req[2] alone is granted first.
- Idle: req=0 for 20 cycles -> SRAM_we_n=1, busy=0, grant=0 throughout.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter_if
// Bundles the request side of the arbiter and the SRAM controller pins.
// Ports summary:
//   req / req_addr / req_we_n / req_wdata : packed per-requester access fields
//   grant / rd_valid                      : one-hot ownership and read tag
//   SRAM_address / SRAM_write_data /
//   SRAM_we_n / SRAM_read_data            : external SRAM port
//   busy                                  : arbiter is in OWN or DRAIN
// Modports:
//   master : system side (engines plus SRAM controller)
//   slave  : the arbiter itself
// SRAM_read_data is routed straight to the engines; the arbiter only tags
// it through rd_valid, so it is not part of the slave modport.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [18*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_we_n;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rd_valid;
  logic [15:0]           SRAM_read_data;
  logic [17:0]           SRAM_address;
  logic [15:0]           SRAM_write_data;
  logic                  SRAM_we_n;
  logic                  busy;

  modport master (
    output req, req_addr, req_we_n, req_wdata, SRAM_read_data,
    input  grant, rd_valid, SRAM_address, SRAM_write_data, SRAM_we_n, busy
  );

  modport slave (
    input  req, req_addr, req_we_n, req_wdata,
    output grant, rd_valid, SRAM_address, SRAM_write_data, SRAM_we_n, busy
  );
endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one external SRAM port between up to four decoder engines. Ownership
// is granted per burst in round-robin order; reads in flight are drained
// before ownership moves on, so returning read data is always tagged to the
// engine that issued it.
// Ports:
//   Clock : system clock, rising edge
//   Reset : asynchronous, active-high reset
//   bus   : sram_port_arbiter_if.slave (requests, grants, SRAM pins, busy)
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sram_port_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int READ_LATENCY = 2,
  parameter int BURST_LIMIT  = 0
) (
  input  wire logic          Clock,
  input  wire logic          Reset,
  sram_port_arbiter_if.slave bus
);

  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [17:0]        sram_address_q, sram_address_d;
  logic [15:0]        sram_write_data_q, sram_write_data_d;
  logic               sram_we_n_q, sram_we_n_d;

  // Stage 0 holds the tag of the access currently on the SRAM pins; stage
  // READ_LATENCY lines up with the matching SRAM_read_data.
  logic [READ_LATENCY:0][NUM_REQ-1:0] tag_q, tag_d;
  logic [NUM_REQ-1:0] tag_in;
  logic               pipe_busy;

  logic               own_req;
  logic [17:0]        own_addr;
  logic               own_we_n;
  logic [15:0]        own_wdata;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] win_onehot;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Current owner's request fields.
  always_comb begin
    own_req   = 1'b0;
    own_addr  = '0;
    own_we_n  = 1'b1;
    own_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_req   = bus.req[i];
        own_addr  = bus.req_addr[18*i +: 18];
        own_we_n  = bus.req_we_n[i];
        own_wdata = bus.req_wdata[16*i +: 16];
      end
    end
  end

  // Round-robin scan starting at rr_ptr; the previous owner sits at the end
  // of the scan because rr_ptr already points past it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = wrap_idx(rr_ptr_q, i);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_onehot[i] = (win_idx == IDX_W'(i));
    end
  end

  // Stage READ_LATENCY only carries the tag being presented now, so the
  // handover may proceed once the earlier stages are empty.
  assign pipe_busy = |tag_q[READ_LATENCY-1:0];

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    owner_d           = owner_q;
    rr_ptr_d          = rr_ptr_q;
    burst_cnt_d       = burst_cnt_q;
    sram_address_d    = sram_address_q;
    sram_write_data_d = sram_write_data_q;
    sram_we_n_d       = 1'b1;
    tag_in            = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d     = win_onehot;
          owner_d     = win_idx;
          burst_cnt_d = '0;
          state_d     = S_OWN;
        end
      end

      S_OWN: begin
        if (own_req) begin
          sram_address_d    = own_addr;
          sram_write_data_d = own_wdata;
          sram_we_n_d       = own_we_n;
          burst_cnt_d       = burst_cnt_q + 1'b1;
          if (own_we_n) tag_in = grant_q;
          if (BURST_LIMIT > 0 && burst_cnt_q == CNT_W'(BURST_LIMIT - 1)) begin
            grant_d = '0;
            state_d = S_DRAIN;
          end
        end else begin
          grant_d = '0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (!pipe_busy) begin
          rr_ptr_d = wrap_idx(owner_q, 1);
          state_d  = S_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    tag_d = {tag_q[READ_LATENCY-1:0], tag_in};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q           <= S_IDLE;
      grant_q           <= '0;
      owner_q           <= '0;
      rr_ptr_q          <= '0;
      burst_cnt_q       <= '0;
      sram_address_q    <= '0;
      sram_write_data_q <= '0;
      sram_we_n_q       <= 1'b1;
      tag_q             <= '0;
    end else begin
      state_q           <= state_d;
      grant_q           <= grant_d;
      owner_q           <= owner_d;
      rr_ptr_q          <= rr_ptr_d;
      burst_cnt_q       <= burst_cnt_d;
      sram_address_q    <= sram_address_d;
      sram_write_data_q <= sram_write_data_d;
      sram_we_n_q       <= sram_we_n_d;
      tag_q             <= tag_d;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.rd_valid        = tag_q[READ_LATENCY];
  assign bus.SRAM_address    = sram_address_q;
  assign bus.SRAM_write_data = sram_write_data_q;
  assign bus.SRAM_we_n       = sram_we_n_q;
  assign bus.busy            = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter. Instance dut_a runs with unlimited
// bursts, dut_b with a burst limit of two. A two-cycle SRAM model returns
// 16'hA000 + address[15:0] for every address placed on the pins.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_port_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 Clock = ~Clock;

  sram_port_arbiter_if #(.NUM_REQ(3)) bus_a ();
  sram_port_arbiter_if #(.NUM_REQ(3)) bus_b ();

  sram_port_arbiter #(.NUM_REQ(3), .READ_LATENCY(2), .BURST_LIMIT(0)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  sram_port_arbiter #(.NUM_REQ(3), .READ_LATENCY(2), .BURST_LIMIT(2)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  // SRAM model: data for an address on the pins arrives two cycles later.
  logic [17:0] a1_a, a1_b;
  always @(posedge Clock) begin
    a1_a <= bus_a.SRAM_address;
    a1_b <= bus_b.SRAM_address;
    bus_a.SRAM_read_data <= 16'hA000 + a1_a[15:0];
    bus_b.SRAM_read_data <= 16'hA000 + a1_b[15:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] exp_grant, exp_rdv;
  logic       exp_busy;
  logic [2:0] owners [8];
  logic [2:0] prev_grant;
  int         bursts, hi_len;
  logic [15:0] exp_data;

  initial begin
    bus_a.req = '0; bus_a.req_addr = '0; bus_a.req_we_n = '1; bus_a.req_wdata = '0;
    bus_b.req = '0; bus_b.req_addr = '0; bus_b.req_we_n = '1; bus_b.req_wdata = '0;
    for (int k = 0; k < 8; k++) owners[k] = '0;

    // ---------------- reset state ----------------
    @(negedge Clock);
    check("rst_grant", {29'd0, bus_a.grant}, 32'd0);
    check("rst_we_n", {31'd0, bus_a.SRAM_we_n}, 32'd1);
    check("rst_addr", {14'd0, bus_a.SRAM_address}, 32'd0);
    check("rst_wdata", {16'd0, bus_a.SRAM_write_data}, 32'd0);
    check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    check("rst_rdv", {29'd0, bus_a.rd_valid}, 32'd0);
    check("rst_grant_b", {29'd0, bus_b.grant}, 32'd0);
    Reset = 1'b0;

    // ---------------- single read burst, addr 0..3 ----------------
    bus_a.req = 3'b001;
    bus_a.req_addr[0 +: 18] = 18'd0;
    @(negedge Clock);
    check("t1_grant_rise", {29'd0, bus_a.grant}, 32'd1);
    check("t1_no_access", {31'd0, bus_a.SRAM_we_n}, 32'd1);
    for (int n = 2; n <= 8; n++) begin
      @(negedge Clock);
      if (n <= 5) begin
        check("t1_addr", {14'd0, bus_a.SRAM_address}, n - 2);
        check("t1_we_n", {31'd0, bus_a.SRAM_we_n}, 32'd1);
      end
      exp_rdv = (n >= 4 && n <= 7) ? 3'b001 : 3'b000;
      check("t1_rdv", {29'd0, bus_a.rd_valid}, {29'd0, exp_rdv});
      if (n >= 4 && n <= 7)
        check("t1_rdata", {16'd0, bus_a.SRAM_read_data}, 32'hA000 + n - 4);
      check("t1_grant", {29'd0, bus_a.grant}, (n <= 5) ? 32'd1 : 32'd0);
      check("t1_busy", {31'd0, bus_a.busy}, (n <= 7) ? 32'd1 : 32'd0);
      if (n < 5) bus_a.req_addr[0 +: 18] = 18'(n - 1);
      else if (n == 5) bus_a.req = 3'b000;
    end

    // ---------------- write by 1, then read by 2 ----------------
    bus_a.req = 3'b110;
    bus_a.req_we_n = 3'b101;
    bus_a.req_addr[18 +: 18] = 18'd146944;
    bus_a.req_wdata[16 +: 16] = 16'h1234;
    bus_a.req_addr[36 +: 18] = 18'd38400;
    for (int n = 9; n <= 17; n++) begin
      @(negedge Clock);
      case (n)
        9, 10:   exp_grant = 3'b010;
        13, 14:  exp_grant = 3'b100;
        default: exp_grant = 3'b000;
      endcase
      check("t3_grant", {29'd0, bus_a.grant}, {29'd0, exp_grant});
      check("t3_we_n", {31'd0, bus_a.SRAM_we_n}, (n == 10) ? 32'd0 : 32'd1);
      check("t3_rdv1", {31'd0, bus_a.rd_valid[1]}, 32'd0);
      check("t3_rdv", {29'd0, bus_a.rd_valid}, (n == 16) ? 32'd4 : 32'd0);
      check("t3_busy", {31'd0, bus_a.busy}, (n == 12 || n == 17) ? 32'd0 : 32'd1);
      if (n == 10) begin
        check("t3_waddr", {14'd0, bus_a.SRAM_address}, 32'd146944);
        check("t3_wdata", {16'd0, bus_a.SRAM_write_data}, 32'h1234);
        bus_a.req = 3'b100;
      end
      if (n == 14) begin
        check("t3_raddr", {14'd0, bus_a.SRAM_address}, 32'd38400);
        bus_a.req = 3'b000;
      end
      if (n == 16) check("t3_rdata", {16'd0, bus_a.SRAM_read_data}, 32'h3600);
    end

    // ---------------- drain before handover ----------------
    bus_a.req = 3'b011;
    bus_a.req_we_n = 3'b111;
    bus_a.req_addr[0 +: 18] = 18'd5;
    bus_a.req_addr[18 +: 18] = 18'd7;
    for (int n = 18; n <= 26; n++) begin
      @(negedge Clock);
      case (n)
        18, 19, 20: exp_grant = 3'b001;
        24:         exp_grant = 3'b010;
        default:    exp_grant = 3'b000;
      endcase
      check("t4_grant", {29'd0, bus_a.grant}, {29'd0, exp_grant});
      check("t4_rdv", {29'd0, bus_a.rd_valid}, (n == 21 || n == 22) ? 32'd1 : 32'd0);
      check("t4_busy", {31'd0, bus_a.busy}, (n == 23 || n == 26) ? 32'd0 : 32'd1);
      if (n == 19) begin
        check("t4_addr5", {14'd0, bus_a.SRAM_address}, 32'd5);
        bus_a.req_addr[0 +: 18] = 18'd6;
      end
      if (n == 20) begin
        check("t4_addr6", {14'd0, bus_a.SRAM_address}, 32'd6);
        bus_a.req = 3'b010;
      end
      if (n == 21) check("t4_rdata5", {16'd0, bus_a.SRAM_read_data}, 32'hA005);
      if (n == 22) check("t4_rdata6", {16'd0, bus_a.SRAM_read_data}, 32'hA006);
      if (n == 24) bus_a.req = 3'b000;
    end

    // ---------------- reset mid-burst ----------------
    bus_a.req = 3'b001;
    bus_a.req_addr[0 +: 18] = 18'd10;
    @(negedge Clock);
    check("t5_grant", {29'd0, bus_a.grant}, 32'd1);
    @(negedge Clock);
    bus_a.req_addr[0 +: 18] = 18'd11;
    @(negedge Clock);
    check("t5_addr11", {14'd0, bus_a.SRAM_address}, 32'd11);
    Reset = 1'b1;
    bus_a.req = 3'b000;
    #1;
    check("t5_rst_grant", {29'd0, bus_a.grant}, 32'd0);
    check("t5_rst_we_n", {31'd0, bus_a.SRAM_we_n}, 32'd1);
    check("t5_rst_busy", {31'd0, bus_a.busy}, 32'd0);
    check("t5_rst_addr", {14'd0, bus_a.SRAM_address}, 32'd0);
    check("t5_rst_rdv", {29'd0, bus_a.rd_valid}, 32'd0);
    for (int n = 30; n <= 33; n++) begin
      @(negedge Clock);
      check("t5_rdv_quiet", {29'd0, bus_a.rd_valid}, 32'd0);
      if (n == 31) begin
        Reset = 1'b0;
        bus_a.req = 3'b100;
      end
      if (n == 32) begin
        check("t5_grant2", {29'd0, bus_a.grant}, 32'd4);
        bus_a.req = 3'b000;
      end
    end
    @(negedge Clock);

    // ---------------- idle ----------------
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      check("t6_idle", {27'd0, bus_a.SRAM_we_n, bus_a.busy, bus_a.grant}, 32'b10000);
    end

    // ---------------- contention, burst limit 2 ----------------
    bus_b.req_we_n = 3'b111;
    bus_b.req_addr[0 +: 18]  = 18'h10;
    bus_b.req_addr[18 +: 18] = 18'h20;
    bus_b.req_addr[36 +: 18] = 18'h30;
    bus_b.req = 3'b111;
    bursts = 0;
    hi_len = 0;
    prev_grant = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock);
      check("t2_onehot0", {31'd0, $onehot0(bus_b.grant)}, 32'd1);
      if (bus_b.grant != 3'b000) begin
        if (prev_grant == 3'b000) begin
          if (bursts < 8) owners[bursts] = bus_b.grant;
          bursts++;
          hi_len = 0;
        end else begin
          check("t2_no_switch", {29'd0, bus_b.grant}, {29'd0, prev_grant});
        end
        hi_len++;
      end else if (prev_grant != 3'b000) begin
        check("t2_burst_len", hi_len, 32'd2);
      end
      if (bus_b.rd_valid != 3'b000) begin
        check("t2_rdv_owner", {29'd0, bus_b.rd_valid}, {29'd0, owners[bursts-1]});
        case (bus_b.rd_valid)
          3'b001:  exp_data = 16'hA010;
          3'b010:  exp_data = 16'hA020;
          default: exp_data = 16'hA030;
        endcase
        check("t2_rdata", {16'd0, bus_b.SRAM_read_data}, {16'd0, exp_data});
      end
      prev_grant = bus_b.grant;
    end
    check("t2_burst_count", {31'd0, bursts >= 4}, 32'd1);
    check("t2_owner0", {29'd0, owners[0]}, 32'd1);
    check("t2_owner1", {29'd0, owners[1]}, 32'd2);
    check("t2_owner2", {29'd0, owners[2]}, 32'd4);
    check("t2_owner3", {29'd0, owners[3]}, 32'd1);
    bus_b.req = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
